// File: rtl/cordic_sweep_ctrl.sv
// Angle sequencer and result capture wrapped around a free-running CORDIC rotator.
// Holds z0/mu steady for a full settle window, then presents one tagged cos/sin sample per angle.
module cordic_sweep_ctrl #(
    parameter int SETTLE_CYCLES = 30,
    parameter int W             = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [6:0]          i_z_first,
    input  logic [6:0]          i_z_last,
    input  logic [6:0]          i_z_step,
    input  logic [1:0]          i_mu_cfg,
    output logic [6:0]          o_z0,
    output logic [1:0]          o_mu,
    input  logic signed [W-1:0] i_cos_z,
    input  logic signed [W-1:0] i_sin_z,
    output logic                o_out_valid,
    input  logic                i_out_ready,
    output logic signed [W-1:0] o_out_cos,
    output logic signed [W-1:0] o_out_sin,
    output logic [6:0]          o_out_angle,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err
);

    localparam int             CW       = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [6:0]     Z_MAX    = 7'd71;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_PRESENT
    } state_t;

    state_t                r_state, w_state_next;
    logic [CW-1:0]         r_cnt, w_cnt_next;
    logic [6:0]            r_z0, w_z0_next;
    logic [1:0]            r_mu, w_mu_next;
    logic [6:0]            r_last, w_last_next;
    logic [6:0]            r_step, w_step_next;
    logic [6:0]            r_angle, w_angle_next;
    logic signed [W-1:0]   r_cos, w_cos_next;
    logic signed [W-1:0]   r_sin, w_sin_next;
    logic                  r_valid, w_valid_next;
    logic                  r_done, w_done_next;
    logic                  r_err, w_err_next;
    logic                  w_cfg_bad;
    logic [7:0]            w_next_z;

    assign w_cfg_bad = (i_z_first > Z_MAX) || (i_z_last > Z_MAX) || (i_z_first > i_z_last);
    // 8-bit sum so a step past 127 can never wrap back into the legal range
    assign w_next_z  = {1'b0, r_z0} + {1'b0, r_step};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_z0    <= '0;
            r_mu    <= '0;
            r_last  <= '0;
            r_step  <= '0;
            r_angle <= '0;
            r_cos   <= '0;
            r_sin   <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_z0    <= w_z0_next;
            r_mu    <= w_mu_next;
            r_last  <= w_last_next;
            r_step  <= w_step_next;
            r_angle <= w_angle_next;
            r_cos   <= w_cos_next;
            r_sin   <= w_sin_next;
            r_valid <= w_valid_next;
            r_done  <= w_done_next;
            r_err   <= w_err_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_z0_next    = r_z0;
        w_mu_next    = r_mu;
        w_last_next  = r_last;
        w_step_next  = r_step;
        w_angle_next = r_angle;
        w_cos_next   = r_cos;
        w_sin_next   = r_sin;
        w_valid_next = r_valid;
        w_done_next  = 1'b0;
        w_err_next   = r_err;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (w_cfg_bad) begin
                        w_err_next  = 1'b1;
                        w_done_next = 1'b1;
                    end else begin
                        w_err_next   = 1'b0;
                        w_last_next  = i_z_last;
                        w_step_next  = (i_z_step == 7'd0) ? 7'd1 : i_z_step;
                        w_z0_next    = i_z_first;
                        w_mu_next    = i_mu_cfg;
                        w_cnt_next   = '0;
                        w_state_next = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                // z0 has been stable long enough for a pass that both starts and ends on it
                if (r_cnt == CNT_LAST) begin
                    w_cos_next   = i_cos_z;
                    w_sin_next   = i_sin_z;
                    w_angle_next = r_z0;
                    w_valid_next = 1'b1;
                    w_state_next = S_PRESENT;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_PRESENT: begin
                if (r_valid && i_out_ready) begin
                    w_valid_next = 1'b0;
                    if (w_next_z > {1'b0, r_last}) begin
                        w_done_next  = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_z0_next    = w_next_z[6:0];
                        w_cnt_next   = '0;
                        w_state_next = S_SETTLE;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign o_z0        = r_z0;
    assign o_mu        = r_mu;
    assign o_out_valid = r_valid;
    assign o_out_cos   = r_cos;
    assign o_out_sin   = r_sin;
    assign o_out_angle = r_angle;
    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = r_done;
    assign o_err       = r_err;

endmodule
